// File: rtl/alu_rr_scheduler_if.sv
// alu_rr_scheduler_if
//   Bundles every handshake and bus signal around the round-robin ALU
//   scheduler: two command channels, the ALU issue/result path and the
//   response channel.
//
//   Signals:
//     req0_* / req1_*  command channels (valid, ready, a, b, fun)
//     alu_a/b/fun      operands and function code sent to the ALU
//     alu_en           one-cycle issue pulse to the ALU
//     alu_out/flag     registered ALU result and its valid flag
//     rsp_*            response channel (valid, ready, id, data, err)
//
//   Modports:
//     master  the scheduler's view (drives ready, ALU controls, responses)
//     slave   the surroundings' view (requesters, ALU, response consumer)

interface alu_rr_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic [FUN_WIDTH-1:0]  req0_fun;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic [FUN_WIDTH-1:0]  req1_fun;

  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [FUN_WIDTH-1:0]  alu_fun;
  logic                  alu_en;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  alu_flag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    input  req0_valid, req0_a, req0_b, req0_fun,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_fun,
    output req1_ready,
    output alu_a, alu_b, alu_fun, alu_en,
    input  alu_out, alu_flag,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req0_valid, req0_a, req0_b, req0_fun,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_fun,
    input  req1_ready,
    input  alu_a, alu_b, alu_fun, alu_en,
    output alu_out, alu_flag,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one registered ALU between two requesters in round-robin order.
//   A command is accepted in IDLE, issued with a one-cycle alu_en pulse,
//   the scheduler then waits for alu_flag (or times out after LAT_MAX wait
//   cycles) and finally holds the response until the consumer takes it.
//   At most one operation is in flight.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     bus        alu_rr_scheduler_if.master (command, ALU and response buses)
//   Optional (macro ALU_SCHED_STATS_EN defined):
//     stat_ops0  16-bit saturating count of responses handed off for id 0
//     stat_ops1  16-bit saturating count of responses handed off for id 1
//     stat_tmo   8-bit saturating count of handed-off timeout responses
//
//   Parameters: DATA_WIDTH (operand/result width), FUN_WIDTH (function code
//   width), LAT_MAX (wait cycles before timeout, at least 1).

module alu_rr_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4,
  parameter int LAT_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_rr_scheduler_if.master    bus
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_ops0,
  output logic [15:0]           stat_ops1,
  output logic [7:0]            stat_tmo
`endif
);

  localparam int CNT_W = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  rr_ptr;
  logic [CNT_W-1:0]      wait_cnt;

  logic [DATA_WIDTH-1:0] cap_a;
  logic [DATA_WIDTH-1:0] cap_b;
  logic [FUN_WIDTH-1:0]  cap_fun;
  logic                  cap_id;

  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic [1:0]            req_valid;
  logic                  grant_ok;
  logic                  grant_id;
  logic                  ready0;
  logic                  ready1;
  logic                  alu_en;
  logic                  rsp_valid;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake decode. The pointer's requester wins a tie;
  // otherwise whichever side is valid is served. Ready, issue and response
  // strobes are held low while rst is asserted so nothing leaks out of reset.
  always_comb begin
    next_state = state;
    grant_ok   = 1'b0;
    grant_id   = rr_ptr;
    ready0     = 1'b0;
    ready1     = 1'b0;
    alu_en     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid[rr_ptr]) begin
          grant_ok = 1'b1;
          grant_id = rr_ptr;
        end else if (req_valid[~rr_ptr]) begin
          grant_ok = 1'b1;
          grant_id = ~rr_ptr;
        end
        ready0 = grant_ok && !grant_id && !rst;
        ready1 = grant_ok && grant_id && !rst;
        if (grant_ok) begin
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        alu_en     = !rst;
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.alu_flag || (wait_cnt == CNT_LAST)) begin
          next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = !rst;
        if (bus.rsp_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Datapath: capture the granted command, run the wait counter and load the
  // response. A flag in the same cycle as the timeout takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 1'b0;
      wait_cnt <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      cap_fun  <= '0;
      cap_id   <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            cap_a   <= grant_id ? bus.req1_a   : bus.req0_a;
            cap_b   <= grant_id ? bus.req1_b   : bus.req0_b;
            cap_fun <= grant_id ? bus.req1_fun : bus.req0_fun;
            cap_id  <= grant_id;
            rr_ptr  <= ~grant_id;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (bus.alu_flag) begin
            rsp_data <= bus.alu_out;
            rsp_err  <= 1'b0;
            rsp_id   <= cap_id;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            rsp_id   <= cap_id;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.alu_a      = cap_a;
  assign bus.alu_b      = cap_b;
  assign bus.alu_fun    = cap_fun;
  assign bus.alu_en     = alu_en;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_err    = rsp_err;

`ifdef ALU_SCHED_STATS_EN
  logic handoff;

  assign handoff = rsp_valid && bus.rsp_ready;

  // Saturating statistics, counted only when a response is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops0 <= '0;
      stat_ops1 <= '0;
      stat_tmo  <= '0;
    end else if (handoff) begin
      if (!rsp_id && (stat_ops0 != '1)) begin
        stat_ops0 <= stat_ops0 + 16'd1;
      end
      if (rsp_id && (stat_ops1 != '1)) begin
        stat_ops1 <= stat_ops1 + 16'd1;
      end
      if (rsp_err && (stat_tmo != '1)) begin
        stat_tmo <= stat_tmo + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler
//   Self-checking bench for alu_rr_scheduler. A behavioural ALU with a
//   programmable latency (or a muted flag) sits on the ALU side; a small
//   reference model tracks the round-robin preference, the expected result
//   of each accepted command and its response latency.
//   Optional macro ALU_SCHED_STATS_EN also checks the statistics ports.

module tb_alu_rr_scheduler;

  localparam int DW      = 16;
  localparam int FW      = 4;
  localparam int LAT_MAX = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_rr_scheduler_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW)) bus ();

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_ops0;
  logic [15:0] stat_ops1;
  logic [7:0]  stat_tmo;
`endif

  alu_rr_scheduler #(
    .DATA_WIDTH(DW),
    .FUN_WIDTH (FW),
    .LAT_MAX   (LAT_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ALU_SCHED_STATS_EN
    ,
    .stat_ops0(stat_ops0),
    .stat_ops1(stat_ops1),
    .stat_tmo (stat_tmo)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Requester-side stimulus state.
  logic [1:0]    vld;
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb [2];
  logic [FW-1:0] pf [2];

  // Reference model state.
  bit model_rr;
  int ops_cnt [2];
  int tmo_cnt;

  // ALU model controls.
  int   alu_lat;
  bit   alu_mute;
  logic force_flag;

  logic          model_flag;
  logic [DW-1:0] model_out;
  logic [DW-1:0] pend_res;
  bit            pend;
  int            cd;

  // Function codes: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  function automatic logic [DW-1:0] alu_ref(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [FW-1:0] f);
    int unsigned s;
    case (f)
      4'd0:    s = int'(a) + int'(b);
      4'd1:    s = int'(a) + 65536 - int'(b);
      4'd2:    s = int'(a & b);
      4'd3:    s = int'(a | b);
      4'd4:    s = int'(a ^ b);
      default: s = int'(a);
    endcase
    return DW'(s % 65536);
  endfunction

  // Behavioural ALU: result and flag appear alu_lat cycles after alu_en.
  always @(posedge clk) begin
    model_flag <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else if (bus.alu_en) begin
      pend_res <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_fun);
      if (alu_lat <= 1) begin
        if (!alu_mute) begin
          model_flag <= 1'b1;
          model_out  <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_fun);
        end
        pend <= 1'b0;
      end else begin
        pend <= !alu_mute;
        cd   <= alu_lat - 1;
      end
    end else if (pend) begin
      if (cd == 1) begin
        model_flag <= 1'b1;
        model_out  <= pend_res;
        pend       <= 1'b0;
      end else begin
        cd <= cd - 1;
      end
    end
  end

  assign bus.alu_flag = model_flag | force_flag;
  assign bus.alu_out  = model_out;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus();
    bus.req0_valid = vld[0];
    bus.req0_a     = pa[0];
    bus.req0_b     = pb[0];
    bus.req0_fun   = pf[0];
    bus.req1_valid = vld[1];
    bus.req1_a     = pa[1];
    bus.req1_b     = pb[1];
    bus.req1_fun   = pf[1];
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_payload(input int id);
    pa[id] = DW'($urandom);
    pb[id] = DW'($urandom);
    pf[id] = FW'($urandom_range(0, 4));
  endtask

  // One complete operation: grant check, issue, wait, response with
  // optional backpressure, then handshake.
  task automatic run_one(input int hold, input int lat, input bit mute,
                         output logic obs_id);
    int            g;
    int            n;
    int            exp_lat;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [FW-1:0] ef;
    logic [DW-1:0] exp_data;
    alu_lat  = lat;
    alu_mute = mute;
    apply_stimulus();
    #1;
    g = vld[model_rr] ? int'(model_rr) : int'(!model_rr);
    check_output("grant_ready0", 32'(bus.req0_ready), 32'(g == 0));
    check_output("grant_ready1", 32'(bus.req1_ready), 32'(g == 1));
    ea       = pa[g];
    eb       = pb[g];
    ef       = pf[g];
    exp_data = mute ? '0 : alu_ref(ea, eb, ef);
    exp_lat  = 2 + (mute ? LAT_MAX : lat);
    tick();
    model_rr = (g == 0);
    new_payload(g);
    apply_stimulus();
    #1;
    check_output("issue_en", 32'(bus.alu_en), 32'd1);
    check_output("issue_a", 32'(bus.alu_a), 32'(ea));
    check_output("issue_b", 32'(bus.alu_b), 32'(eb));
    check_output("issue_fun", 32'(bus.alu_fun), 32'(ef));
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
      if (!bus.rsp_valid) begin
        check_output("wait_en", 32'(bus.alu_en), 32'd0);
        check_output("wait_a", 32'(bus.alu_a), 32'(ea));
        check_output("wait_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      end
    end
    check_output("rsp_latency", 32'(n), 32'(exp_lat));
    check_output("rsp_id", 32'(bus.rsp_id), 32'(g));
    check_output("rsp_data", 32'(bus.rsp_data), 32'(exp_data));
    check_output("rsp_err", 32'(bus.rsp_err), 32'(mute));
    obs_id = bus.rsp_id;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_output("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_output("hold_id", 32'(bus.rsp_id), 32'(g));
      check_output("hold_data", 32'(bus.rsp_data), 32'(exp_data));
      check_output("hold_err", 32'(bus.rsp_err), 32'(mute));
      check_output("hold_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    check_output("hs_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    check_output("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    ops_cnt[g]++;
    if (mute) tmo_cnt++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    model_rr   = 1'b0;
    ops_cnt[0] = 0;
    ops_cnt[1] = 0;
    tmo_cnt    = 0;
  endtask

  // Safety net in case the design stalls outside a bounded wait.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic id;
    vld            = 2'b01;
    pa[0]          = '0;
    pb[0]          = '0;
    pf[0]          = '0;
    pa[1]          = '0;
    pb[1]          = '0;
    pf[1]          = '0;
    bus.rsp_ready  = 1'b0;
    force_flag     = 1'b0;
    alu_lat        = 1;
    alu_mute       = 1'b0;
    apply_stimulus();

    // Reset held for two cycles with requester 0 asking.
    do_reset(2);
    rst = 1'b1;
    #1;
    check_output("rst_ready0", 32'(bus.req0_ready), 32'd0);
    check_output("rst_ready1", 32'(bus.req1_ready), 32'd0);
    check_output("rst_alu_en", 32'(bus.alu_en), 32'd0);
    check_output("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check_output("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check_output("rst_alu_fun", 32'(bus.alu_fun), 32'd0);
    check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_output("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check_output("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst = 1'b0;
    #1;
    check_output("rel_ready0", 32'(bus.req0_ready), 32'd1);
    check_output("rel_ready1", 32'(bus.req1_ready), 32'd0);

    // Single op: 3 + 4 with nominal one-cycle ALU.
    pa[0] = 16'h0003;
    pb[0] = 16'h0004;
    pf[0] = 4'd0;
    run_one(0, 1, 1'b0, id);
    check_output("single_id", 32'(id), 32'd0);

    // Fairness from a fresh pointer: ties alternate 0,1,0,1.
    do_reset(1);
    vld = 2'b11;
    new_payload(0);
    new_payload(1);
    for (int i = 0; i < 4; i++) begin
      run_one(0, 1, 1'b0, id);
      check_output("fair_id", 32'(id), 32'(i % 2));
    end

    // Backpressure for five cycles with both requesters waiting.
    run_one(5, 1, 1'b0, id);

    // Timeout with a silent ALU, then a flag on the last wait cycle.
    vld = 2'b01;
    run_one(0, 1, 1'b1, id);
    run_one(0, LAT_MAX, 1'b0, id);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      vld = 2'($urandom_range(1, 3));
      run_one(int'($urandom_range(0, 2)), int'($urandom_range(1, LAT_MAX)),
              ($urandom_range(0, 5) == 0), id);
    end

`ifdef ALU_SCHED_STATS_EN
    check_output("stat_ops0", 32'(stat_ops0), 32'(ops_cnt[0]));
    check_output("stat_ops1", 32'(stat_ops1), 32'(ops_cnt[1]));
    check_output("stat_tmo", 32'(stat_tmo), 32'(tmo_cnt));
`endif

    // Reset during WAIT, then a late flag: no response may appear.
    vld      = 2'b01;
    alu_mute = 1'b1;
    apply_stimulus();
    tick();
    tick();
    vld = 2'b00;
    apply_stimulus();
    do_reset(1);
    force_flag = 1'b1;
    tick();
    force_flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_output("midrst_valid", 32'(bus.rsp_valid), 32'd0);
      check_output("midrst_en", 32'(bus.alu_en), 32'd0);
      tick();
    end
`ifdef ALU_SCHED_STATS_EN
    check_output("midrst_ops0", 32'(stat_ops0), 32'd0);
    check_output("midrst_ops1", 32'(stat_ops1), 32'd0);
    check_output("midrst_tmo", 32'(stat_tmo), 32'd0);
`endif
    vld = 2'b11;
    apply_stimulus();
    #1;
    check_output("midrst_ready0", 32'(bus.req0_ready), 32'd1);
    check_output("midrst_ready1", 32'(bus.req1_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Round-robin scheduler that shares one registered 16-bit ALU between two requesters.
- Accepts operand/function requests over valid/ready and issues one ALU operation at a time with a single-cycle enable pulse.
- Waits for the ALU valid flag, then returns the result with the requester ID over a valid/ready response channel.
- Sits between the two command sources and the ALU top.

Parameters:
- DATA_WIDTH, 16, operand and result width.
- FUN_WIDTH, 4, ALU function code width.
- LAT_MAX, 4, maximum WAIT cycles before timeout; must be at least 1.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0_VALID  in  1  requester 0 has a command.
- REQ0_READY  out  1  requester 0 command accepted this cycle.
- REQ0_A, REQ0_B  in  DATA_WIDTH  requester 0 operands.
- REQ0_FUN  in  FUN_WIDTH  requester 0 function code.
- REQ1_VALID, REQ1_READY, REQ1_A, REQ1_B, REQ1_FUN: same as requester 0, for requester 1.
- ALU_A, ALU_B  out  DATA_WIDTH  operands to the ALU.
- ALU_FUN  out  FUN_WIDTH  function code to the ALU.
- ALU_EN  out  1  one-cycle issue pulse.
- ALU_OUT  in  DATA_WIDTH  registered ALU result.
- ALU_FLAG  in  1  ALU result valid.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  1  requester index the response belongs to.
- RSP_DATA  out  DATA_WIDTH  captured result.
- RSP_ERR  out  1  timeout indicator.

Behaviour:
- Reset: RST high at a clock edge forces the following.
  - state=IDLE, rr_ptr=0, wait counter=0.
  - All outputs 0: REQx_READY, ALU_A/B/FUN, ALU_EN, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR.
  - Reset mid-operation abandons the op; no response is produced. A late ALU_FLAG after reset is ignored, since state is IDLE.
- States: IDLE, ISSUE, WAIT, RESP. One operation in flight at most.
- IDLE:
  - grant = requester rr_ptr if its VALID is high, else the other if its VALID is high.
  - REQx_READY = (state==IDLE) & grant==x. This is combinational from VALID and rr_ptr; never both high.
  - On VALID&READY: register A, B, FUN and ID; set rr_ptr = ~granted ID; go to ISSUE.
  - Both VALID with rr_ptr=0: grant 0. The next tie grants 1.
- ISSUE (1 cycle):
  - ALU_EN=1; ALU_A/B/FUN driven from the captured registers.
  - Clear the counter; go to WAIT.
- WAIT:
  - ALU_EN=0; ALU_A/B/FUN held stable.
  - If ALU_FLAG=1: RSP_DATA<=ALU_OUT, RSP_ERR<=0, RSP_ID<=captured ID, go to RESP.
  - Else the counter increments. When counter==LAT_MAX-1 with no flag: RSP_DATA<=0, RSP_ERR<=1, go to RESP.
  - If the flag arrives in the same cycle as the timeout, the flag wins.
  - Nominal ALU (1-cycle registered) raises the flag in the first WAIT cycle.
- RESP:
  - RSP_VALID=1. RSP_DATA/ID/ERR are stable while RSP_VALID=1 and RSP_READY=0.
  - On RSP_READY: RSP_VALID<=0, go to IDLE. No new request is accepted in the same cycle.
- Timing:
  - Minimum op period is 4 cycles: accept, issue, wait, respond.
  - First RSP_VALID appears 3 cycles after the accept edge.
- ALU_FLAG outside WAIT is ignored.
- Width: results are truncated to DATA_WIDTH. Carry and overflow are not forwarded.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined: adds output ports STAT_OPS0 and STAT_OPS1 (16-bit each) and STAT_TMO (8-bit).
  - STAT_OPS0/STAT_OPS1 count responses handed off (RSP_VALID&RSP_READY) per RSP_ID.
  - STAT_TMO counts handed-off responses with RSP_ERR=1.
  - All three saturate at all-ones and clear on RST.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: RST=1 for 2 cycles while REQ0_VALID=1 → all outputs 0, no READY. RST=0 → REQ0_READY=1 in the first cycle.
- Single op: REQ0 A=16'h0003, B=16'h0004, FUN=ADD; model ALU returns 16'h0007 with 1-cycle latency → ALU_EN pulses exactly 1 cycle; RSP_VALID 3 cycles after accept with DATA=16'h0007, ID=0, ERR=0.
- Fairness: REQ0 and REQ1 both held valid for 4 ops → grant order 0,1,0,1; RSP_ID sequence 0,1,0,1.
- Backpressure: RSP_READY=0 for 5 cycles in RESP → RSP_VALID/DATA/ID held; REQ1_READY stays 0 until 1 cycle after the RSP handshake.
- Timeout: ALU_FLAG held 0, LAT_MAX=4 → RSP_VALID 4 WAIT cycles after ISSUE with ERR=1, DATA=0. A flag asserted on the 4th WAIT cycle instead gives ERR=0 and the ALU data.
- Reset mid-WAIT: assert RST, then raise ALU_FLAG afterwards → no RSP_VALID. With ALU_SCHED_STATS_EN defined, all stats read 0.
